alu_operand_loader: RTL and testbench

Front-end entry controller that sits directly upstream of the 6-bit board ALU. It takes raw slide-switch and push-button inputs, debounces the buttons, and steps a 4-state FSM so the user enters operand A, operand B and the opcode in sequence. The registered `a`, `b` and `Op_Code` values drive the ALU's operand and opcode inputs. `ready` tells the display logic that a full operation is latched.

---
 rtl/alu_operand_loader.sv | 186 ++++++++++++++++++
 tb/tb_alu_operand_loader.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/alu_operand_loader.sv
// alu_operand_loader: button-driven entry of operand A, operand B and opcode
// for the board ALU. Each push-button is synchronized, debounced and
// edge-detected. A 4-state FSM captures the switch values in sequence.
// Optional macro ALU_OPCODE_CHECK_EN rejects opcodes 4'hC..4'hF and flags err.

// Per-button conditioning: 2-flop synchronizer, stability counter, rising-edge pulse.
module alu_operand_loader_deb #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_deb_q;
    logic [CW-1:0] r_cnt;

    // Bring the raw button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after it has held for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_deb <= 1'b0;
        end else if (r_sync2 == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            r_deb <= r_sync2;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Delay the debounced level so a press shows up as a single-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_deb_q <= 1'b0;
        else     r_deb_q <= r_deb;
    end

    assign o_press = r_deb & ~r_deb_q;
endmodule

module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sw,
    input  logic [3:0] op_sw,
    input  logic       btn_enter,
    input  logic       btn_clear,
    output logic [5:0] a,
    output logic [5:0] b,
    output logic [3:0] Op_Code,
    output logic [1:0] state,
    output logic       ready,
    output logic       err
);
    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        EXEC    = 2'b11
    } state_t;

    // Index 0 is enter, index 1 is clear.
    logic [1:0] w_btn;
    logic [1:0] w_press;
    assign w_btn = {btn_clear, btn_enter};

    for (genvar g = 0; g < 2; g++) begin : g_btn
        alu_operand_loader_deb #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk     (clk),
            .rst     (rst),
            .i_btn   (w_btn[g]),
            .o_press (w_press[g])
        );
    end

    state_t     r_state, w_state_nxt;
    logic [5:0] r_a, w_a_nxt;
    logic [5:0] r_b, w_b_nxt;
    logic [3:0] r_op, w_op_nxt;
`ifdef ALU_OPCODE_CHECK_EN
    logic       r_err, w_err_nxt;
`endif

    // State and operand registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD_A;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
`ifdef ALU_OPCODE_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_op    <= w_op_nxt;
`ifdef ALU_OPCODE_CHECK_EN
            r_err   <= w_err_nxt;
`endif
        end
    end

    // Next-state and capture logic; clear overrides a simultaneous enter.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_op_nxt    = r_op;
`ifdef ALU_OPCODE_CHECK_EN
        w_err_nxt   = r_err;
`endif
        if (w_press[1]) begin
            w_state_nxt = LOAD_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_op_nxt    = '0;
`ifdef ALU_OPCODE_CHECK_EN
            w_err_nxt   = 1'b0;
`endif
        end else if (w_press[0]) begin
            case (r_state)
                LOAD_A: begin
                    w_a_nxt     = sw;
                    w_state_nxt = LOAD_B;
`ifdef ALU_OPCODE_CHECK_EN
                    w_err_nxt   = 1'b0;
`endif
                end
                LOAD_B: begin
                    w_b_nxt     = sw;
                    w_state_nxt = LOAD_OP;
`ifdef ALU_OPCODE_CHECK_EN
                    w_err_nxt   = 1'b0;
`endif
                end
                LOAD_OP: begin
`ifdef ALU_OPCODE_CHECK_EN
                    if (op_sw >= 4'hC) begin
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_op_nxt    = op_sw;
                        w_state_nxt = EXEC;
                        w_err_nxt   = 1'b0;
                    end
`else
                    w_op_nxt    = op_sw;
                    w_state_nxt = EXEC;
`endif
                end
                default: w_state_nxt = LOAD_A;
            endcase
        end
    end

    assign a       = r_a;
    assign b       = r_b;
    assign Op_Code = r_op;
    assign state   = r_state;
    assign ready   = (r_state == EXEC);
`ifdef ALU_OPCODE_CHECK_EN
    assign err     = r_err;
`else
    assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_alu_operand_loader.sv
// Scoreboard bench for alu_operand_loader with DEBOUNCE_CYCLES=4.
// Stimulus pushes the expected output snapshot and arrival cycle; a monitor
// pops and compares whenever the visible outputs change.
module tb_alu_operand_loader;
    localparam int N   = 4;
    localparam int LAT = N + 3;  // drive at negedge of cycle k -> change seen at negedge of k+LAT

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] sw = '0;
    logic [3:0] op_sw = '0;
    logic       btn_enter = 1'b0;
    logic       btn_clear = 1'b0;
    logic [5:0] a, b;
    logic [3:0] Op_Code;
    logic [1:0] state;
    logic       ready, err;

    alu_operand_loader #(.DEBOUNCE_CYCLES(N)) dut (
        .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw),
        .btn_enter(btn_enter), .btn_clear(btn_clear),
        .a(a), .b(b), .Op_Code(Op_Code), .state(state), .ready(ready), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [19:0] val;  // {a, b, Op_Code, state, ready, err}
    } exp_t;

    exp_t        q[$];
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [19:0] last;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [19:0] snap(logic [5:0] ea, logic [5:0] eb, logic [3:0] eo,
                                         logic [1:0] es, logic er);
        return {ea, eb, eo, es, (es == 2'b11), er};
    endfunction

    // Monitor: every output change must match the head of the scoreboard.
    always @(negedge clk) begin
        logic [19:0] obs;
        exp_t        e;
        obs = {a, b, Op_Code, state, ready, err};
        if (mon_en && obs !== last) begin
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_change: got %h at cycle %0d, required no change from %h",
                         obs, cyc, last);
            end else begin
                e = q.pop_front();
                if (obs !== e.val || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL capture: got %h at cycle %0d, required %h at cycle %0d",
                             obs, cyc, e.val, e.cyc);
                end
            end
        end
        last = obs;
    end

    task automatic check(string name, logic [31:0] got, logic [31:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // Press buttons for `hold` cycles; optionally expect an output snapshot.
    task automatic press(bit ent, bit clr, int hold, bit expect_chg, logic [19:0] ev);
        exp_t e;
        @(negedge clk);
        if (expect_chg) begin
            e.cyc = cyc + LAT;
            e.val = ev;
            q.push_back(e);
        end
        btn_enter = ent;
        btn_clear = clr;
        repeat (hold) @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        repeat (3 * N) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_a", 32'(a), 32'h0);
        check("reset_b", 32'(b), 32'h0);
        check("reset_op", 32'(Op_Code), 32'h0);
        check("reset_state", 32'(state), 32'h0);
        check("reset_ready", 32'(ready), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

        // Main entry sequence.
        sw = 6'h2A; press(1, 0, 10, 1, snap(6'h2A, 6'h00, 4'h0, 2'b01, 1'b0));
        sw = 6'h05; press(1, 0, 10, 1, snap(6'h2A, 6'h05, 4'h0, 2'b10, 1'b0));
        op_sw = 4'h1; press(1, 0, 10, 1, snap(6'h2A, 6'h05, 4'h1, 2'b11, 1'b0));
        check("exec_ready", 32'(ready), 32'h1);
        check("exec_state", 32'(state), 32'h3);

        // Glitches shorter than N cycles are ignored.
        sw = 6'h3F; op_sw = 4'h9;
        press(1, 0, 1, 0, '0);
        press(1, 0, 2, 0, '0);
        press(1, 0, 3, 0, '0);
        check("glitch_state", 32'(state), 32'h3);

        // 4-cycle hold: EXEC -> LOAD_A, values retained.
        press(1, 0, 4, 1, snap(6'h2A, 6'h05, 4'h1, 2'b00, 1'b0));
        // 200-cycle hold: exactly one capture.
        sw = 6'h11; press(1, 0, 200, 1, snap(6'h11, 6'h05, 4'h1, 2'b01, 1'b0));
        check("long_hold_state", 32'(state), 32'h1);
        // Clear from LOAD_B.
        press(0, 1, 10, 1, snap(6'h00, 6'h00, 4'h0, 2'b00, 1'b0));

        // Clear and enter together in LOAD_B: clear wins.
        sw = 6'h3F; press(1, 0, 10, 1, snap(6'h3F, 6'h00, 4'h0, 2'b01, 1'b0));
        sw = 6'h15; press(1, 1, 10, 1, snap(6'h00, 6'h00, 4'h0, 2'b00, 1'b0));

        // Async reset while in LOAD_OP.
        sw = 6'h09; press(1, 0, 10, 1, snap(6'h09, 6'h00, 4'h0, 2'b01, 1'b0));
        sw = 6'h0A; press(1, 0, 10, 1, snap(6'h09, 6'h0A, 4'h0, 2'b10, 1'b0));
        @(negedge clk);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", {12'h0, a, b, Op_Code, state, ready, err}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        mon_en = 1'b1;

`ifdef ALU_OPCODE_CHECK_EN
        sw = 6'h01; press(1, 0, 10, 1, snap(6'h01, 6'h00, 4'h0, 2'b01, 1'b0));
        sw = 6'h02; press(1, 0, 10, 1, snap(6'h01, 6'h02, 4'h0, 2'b10, 1'b0));
        op_sw = 4'hC; press(1, 0, 10, 1, snap(6'h01, 6'h02, 4'h0, 2'b10, 1'b1));
        check("reject_err", 32'(err), 32'h1);
        op_sw = 4'h7; press(1, 0, 10, 1, snap(6'h01, 6'h02, 4'h7, 2'b11, 1'b0));
        check("accept_err", 32'(err), 32'h0);
`else
        sw = 6'h01; press(1, 0, 10, 1, snap(6'h01, 6'h00, 4'h0, 2'b01, 1'b0));
        sw = 6'h02; press(1, 0, 10, 1, snap(6'h01, 6'h02, 4'h0, 2'b10, 1'b0));
        op_sw = 4'hC; press(1, 0, 10, 1, snap(6'h01, 6'h02, 4'hC, 2'b11, 1'b0));
        check("no_check_err", 32'(err), 32'h0);
`endif

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
